// File: rtl/alu_seq.sv
// alu_seq: sequencing ALU for the nic8 datapath.
//   Single-cycle ADD/SUB/ADC/SBC, multi-cycle LSR/ASR/ROR (one bit per clock)
//   and an iterative unsigned shift-add MUL, under a start/busy/done handshake.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   start, op         - operation request (sampled in IDLE) and opcode
//   areg, breg        - operands; breg[CW-1:0] is the shift count
//   assertBarE, dbus  - active-low drive enable and tri-state bus copy of result
//   result            - registered result
//   busy, done        - handshake: busy in RUN/DONE, done one cycle in DONE
//   flagCarry, flagShift, flagZero, flagOverflow - registered flags
//   aIsZero           - combinational areg==0
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] areg,
  input  logic [WIDTH-1:0] breg,
  input  logic             assertBarE,
  output logic [WIDTH-1:0] dbus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             flagCarry,
  output logic             flagShift,
  output logic             flagZero,
  output logic             flagOverflow,
  output logic             aIsZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_r;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;

  logic               sub, use_c, cin, ovf;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      n;
  logic [WIDTH:0]     sh_start, sh_run;

  // One right-shift step. Returns {bit shifted out, new value}.
  // kind = op[1:0]: 00 LSR, 01 ASR, 10 ROR (rotate through flagShift).
  function automatic logic [WIDTH:0] shr_step(input logic [1:0] kind,
                                              input logic [WIDTH-1:0] v,
                                              input logic s);
    logic in_bit;
    case (kind)
      2'b00:   in_bit = 1'b0;
      2'b01:   in_bit = v[WIDTH-1];
      default: in_bit = s;
    endcase
    return {v[0], in_bit, v[WIDTH-1:1]};
  endfunction

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign aIsZero = (areg == '0);
  assign dbus    = assertBarE ? 'z : result;

  // Arithmetic ops complete straight from the live operands on the start edge.
  assign sub   = op[0] & ~op[2];
  assign use_c = op[1] & ~op[2];
  assign cin   = sub ^ (use_c & flagCarry);
  assign b_eff = sub ? ~breg : breg;
  assign sum   = {1'b0, areg} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  // Carry into the MSB recovered from the sum bit, XORed with carry out.
  assign ovf   = (areg[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];

  assign n        = breg[CW-1:0];
  assign sh_start = shr_step(op[1:0], areg, flagShift);
  assign sh_run   = shr_step(op_r[1:0], result, flagShift);
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL)                 state_nxt = RUN;
          else if (op[2] && n > CW'(1))     state_nxt = RUN;
          else                              state_nxt = DONE;
        end
      end
      RUN:     if (cnt == CNT_ONE) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      flagCarry    <= 1'b0;
      flagShift    <= 1'b0;
      flagZero     <= 1'b0;
      flagOverflow <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            mcand  <= {{WIDTH{1'b0}}, areg};
            mplier <= breg;
            prod   <= '0;
            if (op == OP_MUL) begin
              cnt <= CNT_W'(WIDTH);
            end else if (op[2]) begin
              // The first shift happens on this edge; RUN covers the rest.
              cnt <= CNT_W'(n) - CNT_ONE;
              if (n == '0) begin
                result   <= areg;
                flagZero <= (areg == '0);
              end else begin
                {flagShift, result} <= sh_start;
                if (n == CW'(1)) flagZero <= (sh_start[WIDTH-1:0] == '0);
              end
            end else begin
              result       <= sum[WIDTH-1:0];
              flagCarry    <= sum[WIDTH];
              flagOverflow <= ovf;
              flagZero     <= (sum[WIDTH-1:0] == '0);
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNT_ONE;
          if (op_r == OP_MUL) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            // result is only exposed once the product is complete
            if (cnt == CNT_ONE) begin
              result    <= prod_nxt[WIDTH-1:0];
              flagCarry <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
              flagZero  <= (prod_nxt[WIDTH-1:0] == '0);
            end
          end else begin
            {flagShift, result} <= sh_run;
            if (cnt == CNT_ONE) flagZero <= (sh_run[WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
